dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder (target) side of the CPU data-memory interface: decodes `Mem_WrAddr` for every load and store.
- Serves a word-addressed data RAM plus a small memory-mapped peripheral block: GPIO out, synchronised GPIO in, free-running timer with compare, sticky status.
- Sits beside the single-cycle CPU at top level. Loads complete in the same cycle (combinational `ReadData`); stores commit on the rising clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0x0000_0000 .. 4*RAM_WORDS-1.
- MMIO_BASE, 32'h0200_0000, base byte address of the peripheral block (5 words).
- GPIO_W, 8, width of `gpio_out` and `gpio_in`.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store strobe from CPU; write commits at rising clk while high.
- Mem_WrAddr  input  32  byte address for loads and stores; bits [1:0] ignored.
- Mem_WrData  input  32  store data.
- ReadData  output  32  load data, combinational from `Mem_WrAddr`.
- gpio_out  output  GPIO_W  GPIO output register.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- irq  output  1  level, equals STATUS.match.
- bus_err  output  1  registered one-cycle pulse on a store to an unmapped address.

Behaviour:
- Word index = `Mem_WrAddr[31:2]`. Whole-word access only; no byte enables.
- Decode:
  - RAM: addr < 4*RAM_WORDS.
  - MMIO: MMIO_BASE + 0x00..0x10.
  - Everything else is unmapped.
- MMIO map (byte offsets):
  - 0x00 GPIO_OUT: RW, bits [GPIO_W-1:0]; upper read bits are 0.
  - 0x04 GPIO_IN: RO, two-flop synchroniser output, zero-extended; writes ignored.
  - 0x08 TIMER: RW, 32-bit.
  - 0x0C TIMER_CMP: RW, 32-bit.
  - 0x10 STATUS: bit0 = match, sticky, write-1-to-clear; writing 0 has no effect; other bits read 0.
- Reads:
  - Combinational; no registered read path.
  - Unmapped address reads 32'h0.
  - RAM read returns contents before any same-cycle write, since the write lands on the clock edge.
- Writes: take effect at rising clk when MemWrite=1. A store to an unmapped address changes no state and sets `bus_err` high for exactly the next cycle.
- Timer:
  - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A write to TIMER loads `Mem_WrData` and suppresses that cycle's increment; the next cycle counts from the loaded value.
- Match:
  - When registered TIMER == TIMER_CMP (compared before the update), STATUS.match is set on the next edge.
  - Set has priority over a same-cycle W1C.
  - A write to TIMER_CMP uses the new value from the following cycle onward.
- Synchroniser: `gpio_in` reaches GPIO_IN after 2 rising edges.
- Reset (async assert, sync-to-clk deassert handled at top):
  - Values: gpio_out=0, TIMER=0, TIMER_CMP=32'hFFFF_FFFF, STATUS=0, irq=0, bus_err=0, synchroniser flops=0.
  - RAM contents are not reset (undefined until written).
  - Reset asserted mid-store: the store is lost. No state changes while reset is high.
- MemWrite=0: no state change except timer, match and synchroniser advance.

Test Plan:
- RAM: store 32'hDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 -> both return 32'hDEAD_BEEF; load RAM top word +4 (unmapped) -> 0.
- GPIO: store 32'h0000_01A5 to MMIO_BASE+0x00 -> `gpio_out`=8'hA5 and readback 32'h0000_00A5. Drive `gpio_in`=8'h3C -> GPIO_IN still 0 after 1 edge, reads 32'h0000_003C after 2 edges.
- Timer/match:
  - After reset, write TIMER=5 and TIMER_CMP=8 -> TIMER reads 6,7,8 on the following cycles; `irq` rises on the edge after TIMER==8 and stays high.
  - W1C STATUS=1 -> `irq` low next cycle.
  - W1C on the same cycle as a new match -> `irq` stays high.
- Wrap: write TIMER=32'hFFFF_FFFF -> next cycle reads 0. Write TIMER while the counter runs -> loaded value read next cycle, no extra increment.
- Unmapped store to 32'h1000_0000 -> `bus_err` high for exactly one cycle; RAM and MMIO unchanged; load of the same address -> 0.
- Reset: assert `reset` asynchronously between edges during a store to GPIO_OUT -> `gpio_out`=0 immediately, store not applied, TIMER=0, TIMER_CMP=32'hFFFF_FFFF, `irq`=0.

Source files
------------

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus between the CPU (master) and the memory/MMIO responder (slave).
interface dmem_mmio_responder_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output Mem_WrAddr,
        output Mem_WrData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  Mem_WrAddr,
        input  Mem_WrData,
        output ReadData
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus GPIO/timer/status peripheral block.
// Loads are combinational; stores and all peripheral state update on clk.
module dmem_mmio_responder #(
    parameter int unsigned RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0200_0000,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_mmio_responder_if.slave  bus,
    output logic [GPIO_W-1:0]     gpio_out,
    input  logic [GPIO_W-1:0]     gpio_in,
    output logic                  irq,
    output logic                  bus_err
);

    localparam int unsigned AW         = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned WORD_W     = 30;
    localparam int unsigned MMIO_WORDS = 5;

    typedef enum logic [2:0] {
        REG_GPIO_OUT = 3'd0,
        REG_GPIO_IN  = 3'd1,
        REG_TIMER    = 3'd2,
        REG_CMP      = 3'd3,
        REG_STATUS   = 3'd4
    } reg_e;

    logic [31:0]       mem [RAM_WORDS];

    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              match_q, match_d;
    logic              bus_err_q, bus_err_d;

    logic [WORD_W-1:0] word_idx;
    logic [WORD_W-1:0] mmio_off;
    logic [AW-1:0]     ram_idx;
    logic              ram_hit;
    logic              mmio_hit;
    reg_e              reg_sel;
    logic              wr_gpio, wr_timer, wr_cmp, wr_status, ram_we;
    logic              unused_addr_lsbs;

    // Address decode: byte address -> word index, RAM window and MMIO window.
    assign word_idx         = bus.Mem_WrAddr[31:2];
    assign mmio_off         = word_idx - MMIO_BASE[31:2];
    assign ram_hit          = (word_idx < WORD_W'(RAM_WORDS));
    assign mmio_hit         = (mmio_off < WORD_W'(MMIO_WORDS));
    assign reg_sel          = reg_e'(mmio_off[2:0]);
    assign ram_idx          = word_idx[AW-1:0];
    assign unused_addr_lsbs = ^bus.Mem_WrAddr[1:0];

    assign ram_we    = bus.MemWrite & ram_hit;
    assign wr_gpio   = bus.MemWrite & mmio_hit & (reg_sel == REG_GPIO_OUT);
    assign wr_timer  = bus.MemWrite & mmio_hit & (reg_sel == REG_TIMER);
    assign wr_cmp    = bus.MemWrite & mmio_hit & (reg_sel == REG_CMP);
    assign wr_status = bus.MemWrite & mmio_hit & (reg_sel == REG_STATUS);

    // Combinational load path; RAM returns pre-write contents in a store cycle.
    always_comb begin
        bus.ReadData = 32'h0;
        if (ram_hit) begin
            bus.ReadData = mem[ram_idx];
        end else if (mmio_hit) begin
            unique case (reg_sel)
                REG_GPIO_OUT: bus.ReadData = 32'(gpio_out_q);
                REG_GPIO_IN:  bus.ReadData = 32'(sync2_q);
                REG_TIMER:    bus.ReadData = timer_q;
                REG_CMP:      bus.ReadData = cmp_q;
                REG_STATUS:   bus.ReadData = {31'h0, match_q};
                default:      bus.ReadData = 32'h0;
            endcase
        end
    end

    // Next-state for peripheral registers; a new match wins over a same-cycle clear.
    always_comb begin
        gpio_out_d = gpio_out_q;
        timer_d    = timer_q + 32'd1;
        cmp_d      = cmp_q;
        match_d    = (timer_q == cmp_q) | (match_q & ~(wr_status & bus.Mem_WrData[0]));
        bus_err_d  = bus.MemWrite & ~ram_hit & ~mmio_hit;
        if (wr_gpio) begin
            gpio_out_d = bus.Mem_WrData[GPIO_W-1:0];
        end
        if (wr_timer) begin
            timer_d = bus.Mem_WrData;
        end
        if (wr_cmp) begin
            cmp_d = bus.Mem_WrData;
        end
    end

    // Peripheral state registers and the two-flop gpio_in synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            timer_q    <= 32'h0;
            cmp_q      <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            timer_q    <= timer_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // RAM write port; contents are not cleared, only stores during reset are blocked.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            if (ram_we) begin
                mem[ram_idx] <= bus.Mem_WrData;
            end
        end
    end

    assign gpio_out = gpio_out_q;
    assign irq      = match_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed vector table, async reset sequence,
// then randomized traffic against a behavioural model of the memory map.
module tb_dmem_mmio_responder;
    localparam int unsigned RAM_WORDS = 64;
    localparam logic [31:0] MMIO_BASE = 32'h0200_0000;
    localparam int unsigned GPIO_W    = 8;
    localparam logic [31:0] A_GPO = MMIO_BASE;
    localparam logic [31:0] A_GPI = MMIO_BASE + 32'h4;
    localparam logic [31:0] A_TMR = MMIO_BASE + 32'h8;
    localparam logic [31:0] A_CMP = MMIO_BASE + 32'hC;
    localparam logic [31:0] A_STS = MMIO_BASE + 32'h10;
    localparam int NV = 32;
    localparam int NRAND = 500;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_in;
    logic              irq;
    logic              bus_err;

    dmem_mmio_responder_if bus_if();

    dmem_mmio_responder #(
        .RAM_WORDS (RAM_WORDS),
        .MMIO_BASE (MMIO_BASE),
        .GPIO_W    (GPIO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  gin;
        logic        chk_rd;
        logic [31:0] rd;
        logic [7:0]  gout;
        logic        irq;
        logic        berr;
    } vec_t;

    vec_t vecs [NV];
    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] ram_m [RAM_WORDS];
    bit          ram_v [RAM_WORDS];
    logic [31:0] timer_m, cmp_m;
    logic [7:0]  gpo_m;
    bit          match_m, berr_m;
    logic [7:0]  syncq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [7:0] g);
        bus_if.MemWrite   = we;
        bus_if.Mem_WrAddr = a;
        bus_if.Mem_WrData = d;
        gpio_in           = g;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [7:0] g, input logic c, input logic [31:0] rd,
                                input logic [7:0] go, input logic ir, input logic be);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.gin = g; v.chk_rd = c; v.rd = rd;
        v.gout = go; v.irq = ir; v.berr = be;
        return v;
    endfunction

    function automatic void m_reset();
        timer_m = 32'h0;
        cmp_m   = 32'hFFFF_FFFF;
        gpo_m   = 8'h0;
        match_m = 1'b0;
        berr_m  = 1'b0;
        syncq   = '{8'h0, 8'h0};
    endfunction

    // Model load: ok=0 when the location holds undefined RAM contents.
    function automatic void m_read(input logic [31:0] addr, output bit ok, output logic [31:0] val);
        logic [31:0] a;
        a   = addr & ~32'h3;
        ok  = 1'b1;
        val = 32'h0;
        if (a < 4 * RAM_WORDS) begin
            ok  = ram_v[a / 4];
            val = ram_m[a / 4];
        end else if (a >= MMIO_BASE && a < MMIO_BASE + 32'd20) begin
            case ((a - MMIO_BASE) / 4)
                0: val = {24'h0, gpo_m};
                1: val = {24'h0, syncq[0]};
                2: val = timer_m;
                3: val = cmp_m;
                default: val = {31'h0, match_m};
            endcase
        end
    endfunction

    // Model clock edge: everything is computed from pre-edge values.
    function automatic void m_edge(input logic we, input logic [31:0] addr, input logic [31:0] d, input logic [7:0] g);
        logic [31:0] a, off;
        bit ram, mmio, hit;
        a    = addr & ~32'h3;
        ram  = a < 4 * RAM_WORDS;
        mmio = a >= MMIO_BASE && a < MMIO_BASE + 32'd20;
        off  = (a - MMIO_BASE) / 4;
        hit  = (timer_m == cmp_m);
        berr_m  = we && !ram && !mmio;
        match_m = hit || (match_m && !(we && mmio && off == 4 && d[0]));
        if (we && mmio && off == 2) timer_m = d;
        else                        timer_m = timer_m + 1;
        if (we && mmio && off == 3) cmp_m = d;
        if (we && mmio && off == 0) gpo_m = d[7:0];
        if (we && ram) begin
            ram_m[a / 4] = d;
            ram_v[a / 4] = 1'b1;
        end
        syncq.push_back(g);
        void'(syncq.pop_front());
    endfunction

    initial begin
        bit          ok;
        logic [31:0] exp_rd, a, d;
        logic        we;
        logic [7:0]  g;

        vecs[0]  = mk(1, 32'h10, 32'hDEAD_BEEF, 8'h00, 0, 32'h0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 32'h10, 32'h0, 8'h00, 1, 32'hDEAD_BEEF, 8'h00, 0, 0);
        vecs[2]  = mk(0, 32'h13, 32'h0, 8'h00, 1, 32'hDEAD_BEEF, 8'h00, 0, 0);
        vecs[3]  = mk(0, 32'h100, 32'h0, 8'h00, 1, 32'h0, 8'h00, 0, 0);
        vecs[4]  = mk(1, A_GPO, 32'h1A5, 8'h00, 1, 32'h0, 8'hA5, 0, 0);
        vecs[5]  = mk(0, A_GPO, 32'h0, 8'h3C, 1, 32'hA5, 8'hA5, 0, 0);
        vecs[6]  = mk(0, A_GPI, 32'h0, 8'h3C, 1, 32'h0, 8'hA5, 0, 0);
        vecs[7]  = mk(0, A_GPI, 32'h0, 8'h3C, 1, 32'h3C, 8'hA5, 0, 0);
        vecs[8]  = mk(1, 32'h1000_0000, 32'h1234, 8'h3C, 1, 32'h0, 8'hA5, 0, 1);
        vecs[9]  = mk(0, 32'h1000_0000, 32'h0, 8'h3C, 1, 32'h0, 8'hA5, 0, 0);
        vecs[10] = mk(0, 32'h10, 32'h0, 8'h3C, 1, 32'hDEAD_BEEF, 8'hA5, 0, 0);
        vecs[11] = mk(1, A_TMR, 32'd5, 8'h3C, 1, 32'd11, 8'hA5, 0, 0);
        vecs[12] = mk(1, A_CMP, 32'd8, 8'h3C, 1, 32'hFFFF_FFFF, 8'hA5, 0, 0);
        vecs[13] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'd6, 8'hA5, 0, 0);
        vecs[14] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'd7, 8'hA5, 0, 0);
        vecs[15] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'd8, 8'hA5, 1, 0);
        vecs[16] = mk(0, A_STS, 32'h0, 8'h3C, 1, 32'd1, 8'hA5, 1, 0);
        vecs[17] = mk(1, A_STS, 32'h0, 8'h3C, 1, 32'd1, 8'hA5, 1, 0);
        vecs[18] = mk(1, A_STS, 32'h1, 8'h3C, 1, 32'd1, 8'hA5, 0, 0);
        vecs[19] = mk(0, A_STS, 32'h0, 8'h3C, 1, 32'd0, 8'hA5, 0, 0);
        vecs[20] = mk(1, A_TMR, 32'd20, 8'h3C, 1, 32'd13, 8'hA5, 0, 0);
        vecs[21] = mk(1, A_CMP, 32'd22, 8'h3C, 1, 32'd8, 8'hA5, 0, 0);
        vecs[22] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'd21, 8'hA5, 0, 0);
        vecs[23] = mk(0, A_STS, 32'h0, 8'h3C, 1, 32'd0, 8'hA5, 1, 0);
        vecs[24] = mk(1, A_TMR, 32'd22, 8'h3C, 1, 32'd23, 8'hA5, 1, 0);
        vecs[25] = mk(1, A_STS, 32'h1, 8'h3C, 1, 32'd1, 8'hA5, 1, 0);
        vecs[26] = mk(0, A_STS, 32'h0, 8'h3C, 1, 32'd1, 8'hA5, 1, 0);
        vecs[27] = mk(1, A_TMR, 32'hFFFF_FFFF, 8'h3C, 1, 32'd24, 8'hA5, 1, 0);
        vecs[28] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'hFFFF_FFFF, 8'hA5, 1, 0);
        vecs[29] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'd0, 8'hA5, 1, 0);
        vecs[30] = mk(1, A_TMR, 32'd100, 8'h3C, 1, 32'd1, 8'hA5, 1, 0);
        vecs[31] = mk(0, A_TMR, 32'h0, 8'h3C, 1, 32'd100, 8'hA5, 1, 0);

        // Reset state
        drive(1'b0, 32'h0, 32'h0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset gpio_out", 32'(gpio_out), 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
        #1 reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gin);
            #1;
            if (vecs[i].chk_rd) chk($sformatf("v%0d ReadData", i), bus_if.ReadData, vecs[i].rd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].gout));
            chk($sformatf("v%0d irq", i), 32'(irq), 32'(vecs[i].irq));
            chk($sformatf("v%0d bus_err", i), 32'(bus_err), 32'(vecs[i].berr));
        end

        // Async reset asserted mid-store to GPIO_OUT
        @(negedge clk);
        drive(1'b1, A_GPO, 32'hFF, 8'h3C);
        #2 reset = 1'b1;
        #1;
        chk("rst gpio_out", 32'(gpio_out), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        drive(1'b0, A_TMR, 32'h0, 8'h3C);
        #1 chk("rst TIMER", bus_if.ReadData, 32'h0);
        drive(1'b0, A_CMP, 32'h0, 8'h3C);
        #1 chk("rst TIMER_CMP", bus_if.ReadData, 32'hFFFF_FFFF);
        drive(1'b0, A_STS, 32'h0, 8'h3C);
        #1 chk("rst STATUS", bus_if.ReadData, 32'h0);
        drive(1'b0, A_GPI, 32'h0, 8'h3C);
        #1 chk("rst GPIO_IN", bus_if.ReadData, 32'h0);
        drive(1'b1, A_GPO, 32'hFF, 8'h3C);
        @(posedge clk);
        #1;
        chk("rst store lost", 32'(gpio_out), 32'h0);
        chk("rst timer held", 32'(dut.timer_q), 32'h0);
        drive(1'b0, A_GPO, 32'h0, 8'h3C);
        @(posedge clk);
        #2 reset = 1'b0;
        m_reset();
        for (int i = 0; i < RAM_WORDS; i++) ram_v[i] = 1'b0;
        g = 8'h3C;

        // Randomized traffic against the model
        for (int n = 0; n < NRAND; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = ($urandom_range(0, RAM_WORDS - 1) * 4) | $urandom_range(0, 3);
                4, 5, 6, 7: a = MMIO_BASE + $urandom_range(0, 4) * 4 + $urandom_range(0, 3);
                8:          a = MMIO_BASE + 32'd20 + $urandom_range(0, 255) * 4;
                default:    a = 4 * RAM_WORDS + $urandom_range(0, 1000) * 4;
            endcase
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            if ((a & ~32'h3) == A_CMP) d = timer_m + $urandom_range(0, 6);
            if ((a & ~32'h3) == A_TMR && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) g = 8'($urandom);
            @(negedge clk);
            drive(we, a, d, g);
            #1;
            m_read(a, ok, exp_rd);
            if (ok) chk($sformatf("r%0d ReadData @%08h", n, a), bus_if.ReadData, exp_rd);
            @(posedge clk);
            m_edge(we, a, d, g);
            #1;
            chk($sformatf("r%0d gpio_out", n), 32'(gpio_out), 32'(gpo_m));
            chk($sformatf("r%0d irq", n), 32'(irq), 32'(match_m));
            chk($sformatf("r%0d bus_err", n), 32'(bus_err), 32'(berr_m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
